// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the gshare branch predictor: default widths,
// counter constants and FSM state encoding.
package branch_predictor_pkg;
    localparam int DBITS_DEF        = 32;
    localparam int GHR_BITS_DEF     = 8;
    localparam int BTB_IDX_BITS_DEF = 4;
    localparam int INSTSIZE_DEF     = 4;

    // 2-bit counter seed value and saturation bounds
    localparam logic [1:0] WEAK_NT = 2'b01;
    localparam logic [1:0] CNT_MAX = 2'b11;
    localparam logic [1:0] CNT_MIN = 2'b00;

    // INIT sweeps the tables after reset; RUN is terminal until reset
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } bp_state_e;
endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and AGEX-side update bundle for the branch predictor.
// master = pipeline (FE/AGEX), slave = predictor.
interface branch_predictor_if #(
    parameter int DBITS    = 32,
    parameter int GHR_BITS = 8
);
    // fetch lookup
    logic                lookup_valid;
    logic [DBITS-1:0]    lookup_pc;
    logic                pred_taken;
    logic [DBITS-1:0]    pred_target;
    logic [GHR_BITS-1:0] pred_ghr;
    logic                busy;

    // resolved control instruction
    logic                upd_valid;
    logic [DBITS-1:0]    upd_pc;
    logic [DBITS-1:0]    upd_target;
    logic                upd_is_br;
    logic                upd_is_jmp;
    logic                upd_taken;
    logic                upd_mispred;
    logic [GHR_BITS-1:0] upd_ghr;

    // event counters
    logic [31:0]         stat_lookups;
    logic [31:0]         stat_mispreds;

    modport master (
        output lookup_valid, lookup_pc,
        output upd_valid, upd_pc, upd_target, upd_is_br, upd_is_jmp,
               upd_taken, upd_mispred, upd_ghr,
        input  pred_taken, pred_target, pred_ghr, busy,
        input  stat_lookups, stat_mispreds
    );

    modport slave (
        input  lookup_valid, lookup_pc,
        input  upd_valid, upd_pc, upd_target, upd_is_br, upd_is_jmp,
               upd_taken, upd_mispred, upd_ghr,
        output pred_taken, pred_target, pred_ghr, busy,
        output stat_lookups, stat_mispreds
    );
endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// Next-value logic for a 2-bit saturating up/down counter.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       inc,
    output logic [1:0] nxt
);
    // step toward the outcome, sticking at the ends
    always_comb begin
        nxt = cnt;
        if (inc) begin
            if (cnt != CNT_MAX) nxt = cnt + 2'd1;
        end else begin
            if (cnt != CNT_MIN) nxt = cnt - 2'd1;
        end
    end
endmodule

// File: rtl/branch_predictor.sv
// Gshare branch predictor with a direct-mapped BTB.
// Lookup is combinational; training, history repair and the post-reset
// table sweep are registered. BTB_IDX_BITS must lie in 1..GHR_BITS.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int DBITS        = DBITS_DEF,
    parameter int GHR_BITS     = GHR_BITS_DEF,
    parameter int BTB_IDX_BITS = BTB_IDX_BITS_DEF,
    parameter int INSTSIZE     = INSTSIZE_DEF
) (
    input  logic              clk,
    input  logic              reset,
    branch_predictor_if.slave bus
);
    localparam int PHT_DEPTH = 1 << GHR_BITS;
    localparam int BTB_DEPTH = 1 << BTB_IDX_BITS;
    localparam int TAG_BITS  = DBITS - BTB_IDX_BITS - 2;

    // tables: no async reset, the INIT sweep establishes their contents
    logic [1:0]          pht        [PHT_DEPTH];
    logic [BTB_DEPTH-1:0] btb_valid;
    logic [BTB_DEPTH-1:0] btb_is_jmp;
    logic [TAG_BITS-1:0] btb_tag    [BTB_DEPTH];
    logic [DBITS-1:0]    btb_target [BTB_DEPTH];

    bp_state_e           state;
    logic [GHR_BITS-1:0] ptr;
    logic [GHR_BITS-1:0] spec_ghr;
    logic                busy_q;
    logic [31:0]         lookups_q;
    logic [31:0]         mispreds_q;

    // ---------------- lookup path ----------------
    logic [GHR_BITS-1:0]     lk_pidx;
    logic [BTB_IDX_BITS-1:0] lk_bidx;
    logic [TAG_BITS-1:0]     lk_tag;
    logic                    lk_hit;
    logic                    lk_is_jmp;
    logic                    lk_taken;

    assign lk_pidx   = bus.lookup_pc[GHR_BITS+1:2] ^ spec_ghr;
    assign lk_bidx   = bus.lookup_pc[BTB_IDX_BITS+1:2];
    assign lk_tag    = bus.lookup_pc[DBITS-1:BTB_IDX_BITS+2];
    assign lk_hit    = btb_valid[lk_bidx] && (btb_tag[lk_bidx] == lk_tag);
    assign lk_is_jmp = btb_is_jmp[lk_bidx];
    // jumps in the BTB are always taken; branches follow the PHT MSB
    assign lk_taken  = !busy_q && lk_hit && (lk_is_jmp || pht[lk_pidx][1]);

    assign bus.pred_taken    = lk_taken;
    assign bus.pred_target   = lk_taken ? btb_target[lk_bidx]
                                        : bus.lookup_pc + DBITS'(INSTSIZE);
    assign bus.pred_ghr      = spec_ghr;
    assign bus.busy          = busy_q;
    assign bus.stat_lookups  = lookups_q;
    assign bus.stat_mispreds = mispreds_q;

    // ---------------- update path ----------------
    logic [GHR_BITS-1:0]     up_pidx;
    logic [BTB_IDX_BITS-1:0] up_bidx;
    logic [TAG_BITS-1:0]     up_tag;
    logic [1:0]              pht_cur;
    logic [1:0]              pht_nxt;

    // index with the history the instruction was predicted under
    assign up_pidx = bus.upd_pc[GHR_BITS+1:2] ^ bus.upd_ghr;
    assign up_bidx = bus.upd_pc[BTB_IDX_BITS+1:2];
    assign up_tag  = bus.upd_pc[DBITS-1:BTB_IDX_BITS+2];
    assign pht_cur = pht[up_pidx];

    sat_counter2 u_pht_ctr (
        .cnt (pht_cur),
        .inc (bus.upd_taken),
        .nxt (pht_nxt)
    );

    // instruction-aligned PC bits never index anything
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{bus.lookup_pc[1:0], bus.upd_pc[1:0]};

    // table writes: INIT seeds PHT / clears BTB valid, RUN applies training
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            pht[ptr]                        <= WEAK_NT;
            btb_valid[ptr[BTB_IDX_BITS-1:0]] <= 1'b0;
        end else if (bus.upd_valid) begin
            if (bus.upd_is_br) pht[up_pidx] <= pht_nxt;
            if (bus.upd_taken) begin
                btb_valid[up_bidx]  <= 1'b1;
                btb_tag[up_bidx]    <= up_tag;
                btb_target[up_bidx] <= bus.upd_target;
                btb_is_jmp[up_bidx] <= bus.upd_is_jmp;
            end
        end
    end

    // sweep FSM plus speculative history; mispredict repair wins over shift
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= INIT;
            ptr      <= '0;
            busy_q   <= 1'b1;
            spec_ghr <= '0;
        end else begin
            case (state)
                INIT: begin
                    ptr      <= ptr + 1'b1;
                    spec_ghr <= '0;
                    if (ptr == '1) begin
                        state  <= RUN;
                        busy_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (bus.upd_valid && bus.upd_mispred) begin
                        spec_ghr <= bus.upd_is_br ? {bus.upd_ghr[GHR_BITS-2:0], bus.upd_taken}
                                                  : bus.upd_ghr;
                    end else if (bus.lookup_valid && lk_hit && !lk_is_jmp) begin
                        spec_ghr <= {spec_ghr[GHR_BITS-2:0], lk_taken};
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    // wrapping event counters, frozen while the sweep runs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lookups_q  <= '0;
            mispreds_q <= '0;
        end else begin
            if (bus.lookup_valid && !busy_q)                   lookups_q  <= lookups_q + 32'd1;
            if (bus.upd_valid && bus.upd_mispred && !busy_q)   mispreds_q <= mispreds_q + 32'd1;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: lookup expectations are queued as
// stimulus is driven and compared when the prediction appears.
module tb_branch_predictor;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   n_lookups;

    typedef struct {
        string       tag;
        logic        taken;
        logic [31:0] target;
        logic [7:0]  ghr;
    } exp_t;

    exp_t sb_q[$];

    branch_predictor_if #(.DBITS(32), .GHR_BITS(8)) bus ();

    branch_predictor #(
        .DBITS(32), .GHR_BITS(8), .BTB_IDX_BITS(4), .INSTSIZE(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic idle();
        bus.lookup_valid = 1'b0;
        bus.upd_valid    = 1'b0;
        bus.upd_pc       = '0;
        bus.upd_target   = '0;
        bus.upd_is_br    = 1'b0;
        bus.upd_is_jmp   = 1'b0;
        bus.upd_taken    = 1'b0;
        bus.upd_mispred  = 1'b0;
        bus.upd_ghr      = '0;
    endtask

    // one clock: drive, compare prediction at negedge, then cross posedge
    task automatic cyc(input logic lv, input logic [31:0] lpc,
                       input logic uv, input logic [31:0] upc, input logic [31:0] utgt,
                       input logic ubr, input logic ujmp, input logic utk, input logic umis,
                       input logic [7:0] ughr, input string tag,
                       input logic etk, input logic [31:0] etgt, input logic [7:0] eghr);
        exp_t e;
        bus.lookup_valid = lv;
        bus.lookup_pc    = lpc;
        bus.upd_valid    = uv;
        bus.upd_pc       = upc;
        bus.upd_target   = utgt;
        bus.upd_is_br    = ubr;
        bus.upd_is_jmp   = ujmp;
        bus.upd_taken    = utk;
        bus.upd_mispred  = umis;
        bus.upd_ghr      = ughr;
        if (lv) begin
            e.tag = tag; e.taken = etk; e.target = etgt; e.ghr = eghr;
            sb_q.push_back(e);
            n_lookups++;
        end
        @(negedge clk);
        if (lv && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({e.tag, "_taken"},  64'(bus.pred_taken),  64'(e.taken));
            check({e.tag, "_target"}, 64'(bus.pred_target), 64'(e.target));
            check({e.tag, "_ghr"},    64'(bus.pred_ghr),    64'(e.ghr));
        end
        @(posedge clk); #1;
        idle();
    endtask

    task automatic lk(input logic [31:0] pc, input string tag,
                      input logic etk, input logic [31:0] etgt, input logic [7:0] eghr);
        cyc(1'b1, pc, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, tag, etk, etgt, eghr);
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic br,
                       input logic jmp, input logic tk, input logic mis, input logic [7:0] ghr);
        cyc(1'b0, 32'h100, 1'b1, pc, tgt, br, jmp, tk, mis, ghr, "", 1'b0, '0, '0);
    endtask

    // counts negedges with busy high, starting just after reset release
    task automatic count_busy(input string tag);
        int n = 0;
        @(negedge clk);
        while (bus.busy === 1'b1 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        idle();
        check(tag, 64'(n), 64'd256);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge clk);
        check({tag, "_busy"},     64'(bus.busy),          64'd1);
        check({tag, "_taken"},    64'(bus.pred_taken),    64'd0);
        check({tag, "_target"},   64'(bus.pred_target),   64'h104);
        check({tag, "_ghr"},      64'(bus.pred_ghr),      64'd0);
        check({tag, "_lookups"},  64'(bus.stat_lookups),  64'd0);
        check({tag, "_mispreds"}, 64'(bus.stat_mispreds), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        n_checks = 0; n_errors = 0; n_lookups = 0;
        idle();
        bus.lookup_pc = 32'h100;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("rst");

        // restart the sweep from the middle of INIT
        reset = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;

        // traffic during INIT must be ignored and not counted
        bus.lookup_valid = 1'b1;
        bus.lookup_pc    = 32'h100;
        bus.upd_valid    = 1'b1;
        bus.upd_pc       = 32'h100;
        bus.upd_target   = 32'h200;
        bus.upd_is_br    = 1'b1;
        bus.upd_taken    = 1'b1;
        bus.upd_mispred  = 1'b1;
        bus.upd_ghr      = 8'h5A;
        count_busy("busy_len_init");

        check("init_lookups",  64'(bus.stat_lookups),  64'd0);
        check("init_mispreds", 64'(bus.stat_mispreds), 64'd0);
        check("init_ghr",      64'(bus.pred_ghr),      64'd0);
        for (int i = 0; i < 256; i++)
            check($sformatf("pht_init[%0d]", i), 64'(dut.pht[i]), 64'd1);

        // cold BTB: fall-through, history untouched
        lk(32'h100, "cold", 1'b0, 32'h104, 8'h00);
        check("cold_ghr_after", 64'(bus.pred_ghr), 64'h00);

        // train taken branch twice, then predict it
        upd(32'h100, 32'h200, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        upd(32'h100, 32'h200, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        check("pht40_sat3", 64'(dut.pht[8'h40]), 64'd3);
        lk(32'h100, "br_taken", 1'b1, 32'h200, 8'h00);
        check("br_taken_ghr_after", 64'(bus.pred_ghr), 64'h01);

        // jump aliasing into BTB slot 0: predicted regardless of PHT
        upd(32'h140, 32'h080, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        lk(32'h140, "jmp", 1'b1, 32'h080, 8'h01);
        check("jmp_ghr_after", 64'(bus.pred_ghr), 64'h01);
        lk(32'h100, "alias_miss", 1'b0, 32'h104, 8'h01);
        check("alias_ghr_after", 64'(bus.pred_ghr), 64'h01);

        // retrain branch; with ghr=1 its PHT slot is weak NT -> hit, not taken
        upd(32'h100, 32'h200, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        lk(32'h100, "br_nt", 1'b0, 32'h104, 8'h01);
        check("br_nt_ghr_after", 64'(bus.pred_ghr), 64'h02);

        // mispredict repair overrides same-cycle history shift
        cyc(1'b1, 32'h100, 1'b1, 32'h300, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A,
            "mis_lk", 1'b0, 32'h104, 8'h02);
        check("mis_ghr_after", 64'(bus.pred_ghr), 64'hB4);
        check("mis_count1", 64'(bus.stat_mispreds), 64'd1);

        // jump mispredict restores history verbatim
        upd(32'h404, 32'h500, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        check("jmp_mis_ghr", 64'(bus.pred_ghr), 64'h00);
        check("mis_count2", 64'(bus.stat_mispreds), 64'd2);

        // drive counter down past zero: must stick at 0
        repeat (4) upd(32'h100, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        lk(32'h100, "sat0", 1'b0, 32'h104, 8'h00);
        check("sat0_ghr_after", 64'(bus.pred_ghr), 64'h00);

        // 0 -> 1, then lookup concurrent with 1 -> 2 sees the old value
        upd(32'h100, 32'h200, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        cyc(1'b1, 32'h100, 1'b1, 32'h100, 32'h200, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00,
            "same_cyc", 1'b0, 32'h104, 8'h00);
        lk(32'h100, "after_inc", 1'b1, 32'h200, 8'h00);
        check("after_inc_ghr", 64'(bus.pred_ghr), 64'h01);
        lk(32'h404, "jmp2", 1'b1, 32'h500, 8'h01);

        check("stat_lookups", 64'(bus.stat_lookups), 64'(n_lookups));
        check("stat_mispreds", 64'(bus.stat_mispreds), 64'd2);

        // reset deep into RUN with a trained BTB
        repeat (80) @(posedge clk);
        #1;
        reset = 1'b1;
        bus.lookup_pc = 32'h100;
        check_reset_state("run_rst");
        reset = 1'b0;
        count_busy("busy_len_run_rst");
        n_lookups = 0;
        lk(32'h100, "post_rst_miss", 1'b0, 32'h104, 8'h00);
        check("post_rst_lookups", 64'(bus.stat_lookups), 64'(n_lookups));
        check("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
